// File: rtl/idma_txrx_req_scheduler.sv
// Round-robin scheduler sharing one iDMA backend request port between NumReq frontends.
// An in-order tag FIFO routes each backend response back to the requester that issued it.
module idma_txrx_req_scheduler #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned TFLenWidth     = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq*TFLenWidth-1:0]     req_length_i,
    input  logic [NumReq*AddrWidth-1:0]      req_src_addr_i,
    input  logic [NumReq*AddrWidth-1:0]      req_dst_addr_i,
    input  logic [NumReq-1:0]                req_last_i,
    output logic                             be_req_valid_o,
    input  logic                             be_req_ready_i,
    output logic [TFLenWidth-1:0]            be_req_length_o,
    output logic [AddrWidth-1:0]             be_req_src_addr_o,
    output logic [AddrWidth-1:0]             be_req_dst_addr_o,
    output logic                             be_req_last_o,
    input  logic                             be_rsp_valid_i,
    output logic                             be_rsp_ready_o,
    input  logic                             be_rsp_error_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    input  logic [NumReq-1:0]                rsp_ready_i,
    output logic                             rsp_error_o,
    output logic [$clog2(MaxOutstanding):0]  outstanding_o,
    output logic                             unexpected_rsp_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef enum logic {IDLE, OFFER} state_e;

    localparam idx_t LastIdx = idx_t'(NumReq - 1);
    localparam cnt_t MaxCnt  = cnt_t'(MaxOutstanding);

    state_e state_q, state_d;
    idx_t   rr_ptr_q, rr_ptr_d;
    idx_t   sel_q, sel_d;
    idx_t   tag_mem_q [MaxOutstanding];
    idx_t   tag_mem_d [MaxOutstanding];
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    cnt_t   count_q, count_d;
    logic   unexpected_q, unexpected_d;

    logic [TFLenWidth-1:0] len_arr [NumReq];
    logic [AddrWidth-1:0]  src_arr [NumReq];
    logic [AddrWidth-1:0]  dst_arr [NumReq];

    logic        arb_found;
    idx_t        arb_idx;
    idx_t        cand;
    int unsigned cand_sum;
    logic        fifo_full, fifo_empty;
    logic        push, pop;
    idx_t        head;

    for (genvar k = 0; k < NumReq; k++) begin : g_unpack
        assign len_arr[k] = req_length_i[k*TFLenWidth +: TFLenWidth];
        assign src_arr[k] = req_src_addr_i[k*AddrWidth +: AddrWidth];
        assign dst_arr[k] = req_dst_addr_i[k*AddrWidth +: AddrWidth];
    end

    assign fifo_full  = (count_q == MaxCnt);
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    // First valid requester at or after rr_ptr, wrapping modulo NumReq.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand_sum = 32'(rr_ptr_q) + i;
            if (cand_sum >= NumReq) begin
                cand_sum = cand_sum - NumReq;
            end
            cand = idx_t'(cand_sum);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_found && !fifo_full) begin
                    sel_d   = arb_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (be_req_ready_i) begin
                    state_d  = IDLE;
                    rr_ptr_d = (sel_q == LastIdx) ? '0 : sel_q + idx_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o       = '0;
        be_req_valid_o    = 1'b0;
        be_req_length_o   = '0;
        be_req_src_addr_o = '0;
        be_req_dst_addr_o = '0;
        be_req_last_o     = 1'b0;
        if (state_q == OFFER && !rst_i) begin
            be_req_valid_o     = 1'b1;
            req_ready_o[sel_q] = be_req_ready_i;
            be_req_length_o    = len_arr[sel_q];
            be_req_src_addr_o  = src_arr[sel_q];
            be_req_dst_addr_o  = dst_arr[sel_q];
            be_req_last_o      = req_last_i[sel_q];
        end
    end

    // Responses are steered to the FIFO head; nothing is acknowledged while empty.
    always_comb begin
        rsp_valid_o    = '0;
        be_rsp_ready_o = 1'b0;
        rsp_error_o    = 1'b0;
        if (!rst_i) begin
            rsp_error_o = be_rsp_error_i;
            if (!fifo_empty) begin
                rsp_valid_o[head] = be_rsp_valid_i;
                be_rsp_ready_o    = rsp_ready_i[head];
            end
        end
    end

    assign push = (state_q == OFFER) && be_req_ready_i;
    assign pop  = be_rsp_valid_i && be_rsp_ready_o;

    always_comb begin
        tag_mem_d    = tag_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        unexpected_d = unexpected_q | (be_rsp_valid_i & fifo_empty);
        if (push) begin
            tag_mem_d[wr_ptr_q] = sel_q;
            wr_ptr_d            = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    assign outstanding_o    = rst_i ? '0 : count_q;
    assign unexpected_rsp_o = unexpected_q & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            sel_q        <= '0;
            tag_mem_q    <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            unexpected_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            tag_mem_q    <= tag_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            unexpected_q <= unexpected_d;
        end
    end

endmodule

// File: tb/tb_idma_txrx_req_scheduler.sv
// Scenario-driven bench for idma_txrx_req_scheduler; expected grants and response
// routing are queued when stimulus is driven and compared as the DUT handshakes.
module tb_idma_txrx_req_scheduler;

    localparam int NumReq         = 4;
    localparam int TFLenWidth     = 32;
    localparam int AddrWidth      = 32;
    localparam int MaxOutstanding = 4;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic [NumReq-1:0]             req_valid_i;
    logic [NumReq-1:0]             req_ready_o;
    logic [NumReq*TFLenWidth-1:0]  req_length_i;
    logic [NumReq*AddrWidth-1:0]   req_src_addr_i;
    logic [NumReq*AddrWidth-1:0]   req_dst_addr_i;
    logic [NumReq-1:0]             req_last_i;
    logic                          be_req_valid_o;
    logic                          be_req_ready_i;
    logic [TFLenWidth-1:0]         be_req_length_o;
    logic [AddrWidth-1:0]          be_req_src_addr_o;
    logic [AddrWidth-1:0]          be_req_dst_addr_o;
    logic                          be_req_last_o;
    logic                          be_rsp_valid_i;
    logic                          be_rsp_ready_o;
    logic                          be_rsp_error_i;
    logic [NumReq-1:0]             rsp_valid_o;
    logic [NumReq-1:0]             rsp_ready_i;
    logic                          rsp_error_o;
    logic [2:0]                    outstanding_o;
    logic                          unexpected_rsp_o;

    logic [TFLenWidth-1:0] len_a [NumReq];
    logic [AddrWidth-1:0]  src_a [NumReq];
    logic [AddrWidth-1:0]  dst_a [NumReq];

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   exp_grant_q [$];
    int   exp_rsp_q [$];
    logic exp_err_q [$];

    always #5 clk_i = ~clk_i;

    for (genvar k = 0; k < NumReq; k++) begin : g_pack
        assign req_length_i[k*TFLenWidth +: TFLenWidth] = len_a[k];
        assign req_src_addr_i[k*AddrWidth +: AddrWidth] = src_a[k];
        assign req_dst_addr_i[k*AddrWidth +: AddrWidth] = dst_a[k];
    end

    idma_txrx_req_scheduler #(
        .NumReq(NumReq), .TFLenWidth(TFLenWidth),
        .AddrWidth(AddrWidth), .MaxOutstanding(MaxOutstanding)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_length_i(req_length_i), .req_src_addr_i(req_src_addr_i),
        .req_dst_addr_i(req_dst_addr_i), .req_last_i(req_last_i),
        .be_req_valid_o(be_req_valid_o), .be_req_ready_i(be_req_ready_i),
        .be_req_length_o(be_req_length_o), .be_req_src_addr_o(be_req_src_addr_o),
        .be_req_dst_addr_o(be_req_dst_addr_o), .be_req_last_o(be_req_last_o),
        .be_rsp_valid_i(be_rsp_valid_i), .be_rsp_ready_o(be_rsp_ready_o),
        .be_rsp_error_i(be_rsp_error_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_error_o(rsp_error_o), .outstanding_o(outstanding_o),
        .unexpected_rsp_o(unexpected_rsp_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        total_cnt++;
        if ({be_req_valid_o, req_ready_o, be_rsp_ready_o, rsp_valid_o, rsp_error_o,
             unexpected_rsp_o, outstanding_o, be_req_length_o} !== '0)
            $display("[TB] FAIL reset_during: outputs not all zero (req_valid=%0b outst=%0d unexp=%0b)",
                     be_req_valid_o, outstanding_o, unexpected_rsp_o);
        else pass_cnt++;
        rst_i = 1'b0;
        step();
        total_cnt++;
        if ({be_req_valid_o, req_ready_o, be_rsp_ready_o, rsp_valid_o,
             unexpected_rsp_o, outstanding_o} !== '0)
            $display("[TB] FAIL reset_after: outputs not all zero (req_valid=%0b outst=%0d unexp=%0b)",
                     be_req_valid_o, outstanding_o, unexpected_rsp_o);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int g;
        int t;
        req_valid_i    = 4'b0100;
        be_req_ready_i = 1'b1;
        exp_grant_q.push_back(2);
        #1;
        total_cnt++;
        if (be_req_valid_o !== 1'b0)
            $display("[TB] FAIL single_latency: be_req_valid_o got %0b, expected 0", be_req_valid_o);
        else pass_cnt++;
        step();
        g = exp_grant_q.pop_front();
        total_cnt++;
        if (be_req_valid_o !== 1'b1 || req_ready_o !== 4'(1 << g))
            $display("[TB] FAIL single_offer: valid=%0b ready=%b, expected valid=1 ready=%b",
                     be_req_valid_o, req_ready_o, 4'(1 << g));
        else pass_cnt++;
        total_cnt++;
        if ({be_req_length_o, be_req_src_addr_o, be_req_dst_addr_o, be_req_last_o} !==
            {32'd64, 32'h1000, 32'h2000, 1'b0})
            $display("[TB] FAIL single_payload: got len=%0h src=%0h dst=%0h last=%0b, expected 40/1000/2000/0",
                     be_req_length_o, be_req_src_addr_o, be_req_dst_addr_o, be_req_last_o);
        else pass_cnt++;
        exp_rsp_q.push_back(g);
        step();
        req_valid_i = '0;
        total_cnt++;
        if (outstanding_o !== 3'd1 || be_req_valid_o !== 1'b0)
            $display("[TB] FAIL single_accepted: outst=%0d valid=%0b, expected 1/0", outstanding_o, be_req_valid_o);
        else pass_cnt++;
        be_rsp_valid_i = 1'b1;
        rsp_ready_i    = 4'b0100;
        #1;
        t = exp_rsp_q.pop_front();
        total_cnt++;
        if (rsp_valid_o !== 4'(1 << t) || be_rsp_ready_o !== 1'b1)
            $display("[TB] FAIL single_rsp: rsp_valid=%b be_rsp_ready=%0b, expected %b/1",
                     rsp_valid_o, be_rsp_ready_o, 4'(1 << t));
        else pass_cnt++;
        step();
        be_rsp_valid_i = 1'b0;
        rsp_ready_i    = '0;
        total_cnt++;
        if (outstanding_o !== 3'd0)
            $display("[TB] FAIL single_drained: outstanding got %0d, expected 0", outstanding_o);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int g;
        int t;
        int prev_hs = -1;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        foreach (exp_grant_q[i]) exp_grant_q.delete(i);
        exp_grant_q = '{0, 1, 2, 3, 0};
        req_valid_i    = 4'b1111;
        be_req_ready_i = 1'b1;
        rsp_ready_i    = 4'b1111;
        for (int c = 0; c < 60 && exp_grant_q.size() > 0; c++) begin
            be_rsp_valid_i = (outstanding_o != 0);
            #1;
            if (be_rsp_valid_i && be_rsp_ready_o) begin
                t = exp_rsp_q.pop_front();
                total_cnt++;
                if (rsp_valid_o !== 4'(1 << t))
                    $display("[TB] FAIL rr_rsp_route: rsp_valid got %b, expected %b", rsp_valid_o, 4'(1 << t));
                else pass_cnt++;
            end
            if (be_req_valid_o && be_req_ready_i) begin
                g = exp_grant_q.pop_front();
                total_cnt++;
                if (req_ready_o !== 4'(1 << g))
                    $display("[TB] FAIL rr_grant: req_ready got %b, expected %b", req_ready_o, 4'(1 << g));
                else pass_cnt++;
                exp_rsp_q.push_back(g);
                if (prev_hs >= 0) begin
                    total_cnt++;
                    if (c - prev_hs !== 2)
                        $display("[TB] FAIL rr_spacing: handshake gap got %0d, expected 2", c - prev_hs);
                    else pass_cnt++;
                end
                prev_hs = c;
            end
            step();
        end
        req_valid_i = '0;
        if (exp_grant_q.size() != 0) begin
            total_cnt++;
            $display("[TB] FAIL rr_timeout: %0d grants missing, expected 0", exp_grant_q.size());
        end
        for (int c = 0; c < 20 && outstanding_o != 0; c++) begin
            be_rsp_valid_i = 1'b1;
            #1;
            if (be_rsp_ready_o) begin
                t = exp_rsp_q.pop_front();
                total_cnt++;
                if (rsp_valid_o !== 4'(1 << t))
                    $display("[TB] FAIL rr_drain_route: rsp_valid got %b, expected %b", rsp_valid_o, 4'(1 << t));
                else pass_cnt++;
            end
            step();
        end
        be_rsp_valid_i = 1'b0;
        total_cnt++;
        if (outstanding_o !== 3'd0 || exp_rsp_q.size() != 0)
            $display("[TB] FAIL rr_drained: outstanding %0d, pending %0d, expected 0/0", outstanding_o, exp_rsp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int t;
        req_valid_i    = 4'b0010;
        be_req_ready_i = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (be_req_valid_o !== 1'b1 || req_ready_o !== 4'b0000 ||
                {be_req_length_o, be_req_src_addr_o, be_req_dst_addr_o, be_req_last_o} !==
                {len_a[1], src_a[1], dst_a[1], req_last_i[1]})
                $display("[TB] FAIL bp_hold_%0d: valid=%0b ready=%b len=%0h, expected 1/0000/%0h",
                         i, be_req_valid_o, req_ready_o, be_req_length_o, len_a[1]);
            else pass_cnt++;
            step();
        end
        be_req_ready_i = 1'b1;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0010)
            $display("[TB] FAIL bp_release: req_ready got %b, expected 0010", req_ready_o);
        else pass_cnt++;
        exp_rsp_q.push_back(1);
        step();
        req_valid_i = '0;
        total_cnt++;
        if (outstanding_o !== 3'd1)
            $display("[TB] FAIL bp_accepted: outstanding got %0d, expected 1", outstanding_o);
        else pass_cnt++;
        be_rsp_valid_i = 1'b1;
        rsp_ready_i    = 4'b1111;
        #1;
        t = exp_rsp_q.pop_front();
        total_cnt++;
        if (rsp_valid_o !== 4'(1 << t))
            $display("[TB] FAIL bp_rsp_route: rsp_valid got %b, expected %b", rsp_valid_o, 4'(1 << t));
        else pass_cnt++;
        step();
        be_rsp_valid_i = 1'b0;
    endtask

    task automatic test_fill();
        int g;
        int t;
        be_rsp_valid_i = 1'b0;
        req_valid_i    = 4'b1111;
        be_req_ready_i = 1'b1;
        exp_grant_q    = '{2, 3, 0, 1};
        for (int c = 0; c < 30 && outstanding_o != 3'd4; c++) begin
            if (be_req_valid_o && be_req_ready_i) begin
                g = exp_grant_q.pop_front();
                total_cnt++;
                if (req_ready_o !== 4'(1 << g))
                    $display("[TB] FAIL fill_grant: req_ready got %b, expected %b", req_ready_o, 4'(1 << g));
                else pass_cnt++;
                exp_rsp_q.push_back(g);
            end
            step();
        end
        total_cnt++;
        if (outstanding_o !== 3'd4)
            $display("[TB] FAIL fill_full: outstanding got %0d, expected 4", outstanding_o);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (be_req_valid_o !== 1'b0)
                $display("[TB] FAIL fill_stall_%0d: be_req_valid got %0b, expected 0", i, be_req_valid_o);
            else pass_cnt++;
            step();
        end
        be_rsp_valid_i = 1'b1;
        rsp_ready_i    = 4'b1111;
        #1;
        t = exp_rsp_q.pop_front();
        total_cnt++;
        if (be_rsp_ready_o !== 1'b1 || rsp_valid_o !== 4'(1 << t) || be_req_valid_o !== 1'b0)
            $display("[TB] FAIL fill_pop: be_rsp_ready=%0b rsp_valid=%b req_valid=%0b, expected 1/%b/0",
                     be_rsp_ready_o, rsp_valid_o, be_req_valid_o, 4'(1 << t));
        else pass_cnt++;
        step();
        be_rsp_valid_i = 1'b0;
        total_cnt++;
        if (outstanding_o !== 3'd3 || be_req_valid_o !== 1'b0)
            $display("[TB] FAIL fill_after_pop: outst=%0d req_valid=%0b, expected 3/0", outstanding_o, be_req_valid_o);
        else pass_cnt++;
        exp_grant_q.push_back(2);
        step();
        g = exp_grant_q.pop_front();
        total_cnt++;
        if (be_req_valid_o !== 1'b1 || req_ready_o !== 4'(1 << g))
            $display("[TB] FAIL fill_resume: valid=%0b ready=%b, expected 1/%b", be_req_valid_o, req_ready_o, 4'(1 << g));
        else pass_cnt++;
        exp_rsp_q.push_back(g);
        step();
        req_valid_i = '0;
        for (int c = 0; c < 20 && outstanding_o != 0; c++) begin
            be_rsp_valid_i = 1'b1;
            #1;
            if (be_rsp_ready_o) begin
                t = exp_rsp_q.pop_front();
                total_cnt++;
                if (rsp_valid_o !== 4'(1 << t))
                    $display("[TB] FAIL fill_drain_route: rsp_valid got %b, expected %b", rsp_valid_o, 4'(1 << t));
                else pass_cnt++;
            end
            step();
        end
        be_rsp_valid_i = 1'b0;
        total_cnt++;
        if (outstanding_o !== 3'd0 || exp_rsp_q.size() != 0)
            $display("[TB] FAIL fill_drained: outstanding %0d, pending %0d, expected 0/0", outstanding_o, exp_rsp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_ordering();
        int   order [3] = '{3, 1, 2};
        logic err_pat [3] = '{1'b0, 1'b1, 1'b0};
        int   k;
        int   t;
        logic e;
        logic hs;
        be_req_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = order[i];
            req_valid_i = 4'(1 << k);
            exp_err_q.push_back(err_pat[i]);
            hs = 1'b0;
            for (int c = 0; c < 10 && !hs; c++) begin
                if (be_req_valid_o) begin
                    total_cnt++;
                    if (req_ready_o !== 4'(1 << k))
                        $display("[TB] FAIL ord_grant: req_ready got %b, expected %b", req_ready_o, 4'(1 << k));
                    else pass_cnt++;
                    exp_rsp_q.push_back(k);
                    hs = 1'b1;
                end
                step();
            end
            req_valid_i = '0;
            if (!hs) begin
                total_cnt++;
                $display("[TB] FAIL ord_timeout: no grant for requester %0d, expected one", k);
            end
        end
        total_cnt++;
        if (outstanding_o !== 3'd3)
            $display("[TB] FAIL ord_outstanding: got %0d, expected 3", outstanding_o);
        else pass_cnt++;
        rsp_ready_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            be_rsp_valid_i = 1'b1;
            be_rsp_error_i = err_pat[i];
            #1;
            t = exp_rsp_q.pop_front();
            e = exp_err_q.pop_front();
            total_cnt++;
            if (rsp_valid_o !== 4'(1 << t) || rsp_error_o !== e)
                $display("[TB] FAIL ord_rsp_%0d: rsp_valid=%b err=%0b, expected %b/%0b",
                         i, rsp_valid_o, rsp_error_o, 4'(1 << t), e);
            else pass_cnt++;
            step();
        end
        be_rsp_valid_i = 1'b0;
        be_rsp_error_i = 1'b0;
        total_cnt++;
        if (outstanding_o !== 3'd0)
            $display("[TB] FAIL ord_drained: outstanding got %0d, expected 0", outstanding_o);
        else pass_cnt++;
    endtask

    task automatic test_unexpected();
        be_rsp_valid_i = 1'b1;
        rsp_ready_i    = 4'b1111;
        #1;
        total_cnt++;
        if (be_rsp_ready_o !== 1'b0 || rsp_valid_o !== 4'b0000)
            $display("[TB] FAIL unexp_ready: be_rsp_ready=%0b rsp_valid=%b, expected 0/0000", be_rsp_ready_o, rsp_valid_o);
        else pass_cnt++;
        step();
        be_rsp_valid_i = 1'b0;
        total_cnt++;
        if (unexpected_rsp_o !== 1'b1)
            $display("[TB] FAIL unexp_set: flag got %0b, expected 1", unexpected_rsp_o);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (unexpected_rsp_o !== 1'b1)
            $display("[TB] FAIL unexp_sticky: flag got %0b, expected 1", unexpected_rsp_o);
        else pass_cnt++;
        rst_i = 1'b1;
        #1;
        total_cnt++;
        if ({be_req_valid_o, req_ready_o, be_rsp_ready_o, rsp_valid_o,
             unexpected_rsp_o, outstanding_o} !== '0)
            $display("[TB] FAIL unexp_in_reset: unexp=%0b outst=%0d, expected all zero", unexpected_rsp_o, outstanding_o);
        else pass_cnt++;
        step();
        rst_i = 1'b0;
        #1;
        total_cnt++;
        if (unexpected_rsp_o !== 1'b0 || be_req_valid_o !== 1'b0 || outstanding_o !== 3'd0)
            $display("[TB] FAIL unexp_cleared: unexp=%0b valid=%0b outst=%0d, expected 0/0/0",
                     unexpected_rsp_o, be_req_valid_o, outstanding_o);
        else pass_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < NumReq; k++) begin
            len_a[k] = 32'h10 << k;
            src_a[k] = 32'h400 << k;
            dst_a[k] = 32'h800 << k;
        end
        req_last_i     = 4'b1010;
        rst_i          = 1'b1;
        req_valid_i    = '0;
        be_req_ready_i = 1'b0;
        be_rsp_valid_i = 1'b0;
        be_rsp_error_i = 1'b0;
        rsp_ready_i    = '0;

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fill();
        test_ordering();
        test_unexpected();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
